// File: rtl/axi_master_arbiter_w.sv
// ============================================================================
// Module   : axi_master_arbiter_w
// Purpose  : Write-channel grant arbiter for a two-master AXI interconnect.
//            Holds one grant from AW through the B handshake.
// Options  : AXI_WARB_FIXED_PRIO_EN -> master 0 wins ties (default round-robin)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_master_arbiter_w #(
  parameter int IDLE_GAP = 0,
  parameter int GAP_W    = 4
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic m0_AWVALID,
  input  logic m1_AWVALID,
  input  logic s_AWVALID,
  input  logic m_AWREADY,
  input  logic s_WVALID,
  input  logic s_WLAST,
  input  logic m_WREADY,
  input  logic m_BVALID,
  input  logic s_BREADY,
  output logic m0_wgrnt,
  output logic m1_wgrnt,
  output logic wr_busy
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IDLE_GAP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             m0_grant_nxt, m1_grant_nxt, busy_nxt;
  logic             aw_done, aw_done_nxt;
  logic             w_done, w_done_nxt;
  logic             last_grant, last_grant_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;

  logic aw_ev, w_ev, b_ev, any_req, pick_m1;

  assign aw_ev   = s_AWVALID & m_AWREADY;
  assign w_ev    = s_WVALID & m_WREADY & s_WLAST;
  assign b_ev    = m_BVALID & s_BREADY;
  assign any_req = m0_AWVALID | m1_AWVALID;

  // last_grant=1 means master 1 was served most recently
`ifdef AXI_WARB_FIXED_PRIO_EN
  assign pick_m1 = m1_AWVALID & ~m0_AWVALID;
`else
  assign pick_m1 = m1_AWVALID & (~m0_AWVALID | ~last_grant);
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= ST_IDLE;
      m0_wgrnt   <= 1'b0;
      m1_wgrnt   <= 1'b0;
      wr_busy    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      gap_cnt    <= '0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      m0_wgrnt   <= m0_grant_nxt;
      m1_wgrnt   <= m1_grant_nxt;
      wr_busy    <= busy_nxt;
      aw_done    <= aw_done_nxt;
      w_done     <= w_done_nxt;
      gap_cnt    <= gap_cnt_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    m0_grant_nxt   = m0_wgrnt;
    m1_grant_nxt   = m1_wgrnt;
    busy_nxt       = wr_busy;
    aw_done_nxt    = aw_done;
    w_done_nxt     = w_done;
    gap_cnt_nxt    = gap_cnt;
    last_grant_nxt = last_grant;

    case (state)
      ST_IDLE: begin
        if (gap_cnt != '0) begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end else if (any_req) begin
          m0_grant_nxt = ~pick_m1;
          m1_grant_nxt = pick_m1;
          busy_nxt     = 1'b1;
          aw_done_nxt  = 1'b0;
          w_done_nxt   = 1'b0;
          state_nxt    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // AW and the final W beat may land in either order or together
        aw_done_nxt = aw_done | aw_ev;
        w_done_nxt  = w_done | w_ev;
        if ((aw_done | aw_ev) & (w_done | w_ev)) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (b_ev) begin
          last_grant_nxt = m1_wgrnt;
          m0_grant_nxt   = 1'b0;
          m1_grant_nxt   = 1'b0;
          busy_nxt       = 1'b0;
          gap_cnt_nxt    = GAP_LOAD;
          state_nxt      = ST_IDLE;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        m0_grant_nxt = 1'b0;
        m1_grant_nxt = 1'b0;
        busy_nxt     = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire
